// File: rtl/bike_pkg.sv
// Shared constants and helpers for the bicycle-computer blocks.
package bike_pkg;

  localparam int unsigned CLK_HZ   = 2048;
  localparam int unsigned REV_W    = 8;
  localparam int unsigned SPEED_W  = 16;
  localparam int unsigned DIST_W   = 16;
  localparam int unsigned CM_PER_M = 100;

  // Whole metres and leftover centimetres obtained from a centimetre sum (0..354).
  typedef struct packed {
    logic [1:0] carry;
    logic [6:0] rem;
  } cm_split_t;

  localparam logic [8:0] CmX1 = 9'(CM_PER_M);
  localparam logic [8:0] CmX2 = 9'(2 * CM_PER_M);
  localparam logic [8:0] CmX3 = 9'(3 * CM_PER_M);

  // Compare/subtract split; the sum never reaches 400 so three thresholds suffice.
  function automatic cm_split_t split_cm(input logic [8:0] sum);
    cm_split_t r;
    if (sum >= CmX3) begin
      r.carry = 2'd3;
      r.rem   = 7'(sum - CmX3);
    end else if (sum >= CmX2) begin
      r.carry = 2'd2;
      r.rem   = 7'(sum - CmX2);
    end else if (sum >= CmX1) begin
      r.carry = 2'd1;
      r.rem   = 7'(sum - CmX1);
    end else begin
      r.carry = 2'd0;
      r.rem   = 7'(sum);
    end
    return r;
  endfunction

endpackage

// File: rtl/wheel_pulse_conditioner.sv
// Reed-switch conditioning: 2-FF synchronizer, rising-edge detect and a
// post-acceptance lockout that swallows contact bounce.
module wheel_pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic wheel_raw,
  output logic pulse_accepted
);

  localparam logic [7:0] LockoutLoad = 8'(DEBOUNCE_CYCLES);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic       rise;
  logic [7:0] lockout_q;
  logic [7:0] lockout_d;

  // Synchronizer chain plus one history flop for the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= wheel_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise           = sync2_q & ~prev_q;
  assign pulse_accepted = rise & (lockout_q == 8'd0);

  // Reload the lockout on acceptance, otherwise count it down to zero.
  always_comb begin
    lockout_d = lockout_q;
    if (pulse_accepted) begin
      lockout_d = LockoutLoad;
    end else if (lockout_q != 8'd0) begin
      lockout_d = lockout_q - 8'd1;
    end
  end

  // Lockout register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lockout_q <= 8'd0;
    end else begin
      lockout_q <= lockout_d;
    end
  end

endmodule

// File: rtl/wheel_speed_meter.sv
// Wheel speed meter: counts conditioned wheel pulses per 1 s window, latches
// revolutions/s and speed on each tick, accumulates trip distance and flags a
// stopped bike after a run of empty windows.
module wheel_speed_meter
  import bike_pkg::*;
#(
  parameter int unsigned CIRC_CM         = 210,
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned STOP_TICKS      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1s,
  input  logic               wheel_raw,
  input  logic               clear_dist,
  output logic [REV_W-1:0]   rev_per_s,
  output logic [SPEED_W-1:0] speed_cms,
  output logic [DIST_W-1:0]  distance_m,
  output logic               stopped,
  output logic               meas_valid
);

  localparam logic [8:0]         CircSum   = 9'(CIRC_CM);
  localparam logic [SPEED_W-1:0] CircMul   = SPEED_W'(CIRC_CM);
  localparam logic [3:0]         StopTicks = 4'(STOP_TICKS);
  localparam logic [REV_W-1:0]   RevMax    = '1;
  localparam logic [DIST_W-1:0]  DistMax   = '1;

  logic pulse;

  logic [REV_W-1:0]   win_cnt_q, win_cnt_d;
  logic [REV_W-1:0]   rev_q, rev_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               valid_q, valid_d;
  logic [3:0]         zero_ticks_q, zero_ticks_d;
  logic               stopped_q, stopped_d;
  logic [6:0]         cm_acc_q, cm_acc_d;
  logic [DIST_W-1:0]  dist_q, dist_d;

  logic [8:0]         cm_sum;
  cm_split_t          cm_split;
  logic [DIST_W:0]    dist_sum;

  wheel_pulse_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond (
    .clk           (clk),
    .reset         (reset),
    .wheel_raw     (wheel_raw),
    .pulse_accepted(pulse)
  );

  // Window counting and measurement latch; a pulse on the tick edge opens the new window.
  always_comb begin
    win_cnt_d = win_cnt_q;
    rev_d     = rev_q;
    speed_d   = speed_q;
    valid_d   = 1'b0;
    if (tick_1s) begin
      rev_d     = win_cnt_q;
      speed_d   = SPEED_W'(win_cnt_q) * CircMul;
      valid_d   = 1'b1;
      win_cnt_d = pulse ? REV_W'(1) : '0;
    end else if (pulse && (win_cnt_q != RevMax)) begin
      win_cnt_d = win_cnt_q + REV_W'(1);
    end
  end

  // Stop detection: saturating run length of empty windows, evaluated per tick.
  always_comb begin
    zero_ticks_d = zero_ticks_q;
    if (tick_1s) begin
      if (win_cnt_q == '0) begin
        if (zero_ticks_q != StopTicks) begin
          zero_ticks_d = zero_ticks_q + 4'd1;
        end
      end else begin
        zero_ticks_d = 4'd0;
      end
    end
    stopped_d = (zero_ticks_d == StopTicks);
  end

  // Distance: centimetre remainder plus whole-metre carries, clear wins over a pulse.
  always_comb begin
    cm_sum   = {2'b00, cm_acc_q} + CircSum;
    cm_split = split_cm(cm_sum);
    dist_sum = {1'b0, dist_q} + (DIST_W + 1)'(cm_split.carry);
    cm_acc_d = cm_acc_q;
    dist_d   = dist_q;
    if (clear_dist) begin
      cm_acc_d = 7'd0;
      dist_d   = '0;
    end else if (pulse) begin
      cm_acc_d = cm_split.rem;
      dist_d   = dist_sum[DIST_W] ? DistMax : dist_sum[DIST_W-1:0];
    end
  end

  // State registers; the stop run starts full so the bike reads stopped out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q    <= '0;
      rev_q        <= '0;
      speed_q      <= '0;
      valid_q      <= 1'b0;
      zero_ticks_q <= StopTicks;
      stopped_q    <= 1'b1;
      cm_acc_q     <= 7'd0;
      dist_q       <= '0;
    end else begin
      win_cnt_q    <= win_cnt_d;
      rev_q        <= rev_d;
      speed_q      <= speed_d;
      valid_q      <= valid_d;
      zero_ticks_q <= zero_ticks_d;
      stopped_q    <= stopped_d;
      cm_acc_q     <= cm_acc_d;
      dist_q       <= dist_d;
    end
  end

  assign rev_per_s  = rev_q;
  assign speed_cms  = speed_q;
  assign distance_m = dist_q;
  assign stopped    = stopped_q;
  assign meas_valid = valid_q;

endmodule

// File: tb/tb_wheel_speed_meter.sv
// Bench for wheel_speed_meter: directed stimulus, a cycle-level reference model
// compared every cycle, and literal expectations at key points. A second
// instance (no debounce, 255 cm wheel) covers the saturation limits.
module tb_wheel_speed_meter;

  localparam int Circ = 210;
  localparam int Deb  = 20;
  localparam int Stop = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_1s = 1'b0;
  logic        wheel_raw = 1'b0;
  logic        clear_dist = 1'b0;
  logic [7:0]  rev_per_s;
  logic [15:0] speed_cms;
  logic [15:0] distance_m;
  logic        stopped;
  logic        meas_valid;

  logic        rst_s = 1'b1;
  logic        tick_s = 1'b0;
  logic        raw_s = 1'b0;
  logic        clear_s = 1'b0;
  logic [7:0]  rev_s;
  logic [15:0] speed_s;
  logic [15:0] dist_s;
  logic        stopped_s;
  logic        mv_s;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;
  bit sat_done = 1'b0;

  always #5 clk = ~clk;

  wheel_speed_meter #(
    .CIRC_CM(Circ), .DEBOUNCE_CYCLES(Deb), .STOP_TICKS(Stop)
  ) dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s), .wheel_raw(wheel_raw),
    .clear_dist(clear_dist), .rev_per_s(rev_per_s), .speed_cms(speed_cms),
    .distance_m(distance_m), .stopped(stopped), .meas_valid(meas_valid)
  );

  wheel_speed_meter #(
    .CIRC_CM(255), .DEBOUNCE_CYCLES(0), .STOP_TICKS(Stop)
  ) dut_sat (
    .clk(clk), .reset(rst_s), .tick_1s(tick_s), .wheel_raw(raw_s),
    .clear_dist(clear_s), .rev_per_s(rev_s), .speed_cms(speed_s),
    .distance_m(dist_s), .stopped(stopped_s), .meas_valid(mv_s)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples per edge, time since last acceptance, total
  // centimetres since clear and the length of the current empty-window run.
  bit     smp[$];
  int     ecnt, last_acc, m_cnt, m_rev, m_zero;
  longint m_cm;
  bit     m_mv, m_pulse;

  function automatic void model_reset();
    smp = {};
    smp.push_back(1'b0);
    smp.push_back(1'b0);
    smp.push_back(1'b0);
    ecnt = 0;
    last_acc = -1000;
    m_cnt = 0;
    m_rev = 0;
    m_zero = Stop;
    m_cm = 0;
    m_mv = 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      ecnt++;
      // A rise seen at the raw input two edges ago becomes a pulse now.
      m_pulse = smp[smp.size()-2] && !smp[smp.size()-3] && (ecnt - last_acc > Deb);
      if (m_pulse) last_acc = ecnt;
      smp.push_back(wheel_raw);
      if (smp.size() > 6) void'(smp.pop_front());
      if (tick_1s) begin
        m_rev = m_cnt;
        m_mv = 1'b1;
        m_zero = (m_cnt == 0) ? m_zero + 1 : 0;
        m_cnt = m_pulse ? 1 : 0;
      end else begin
        m_mv = 1'b0;
        if (m_pulse && m_cnt < 255) m_cnt++;
      end
      if (clear_dist) m_cm = 0;
      else if (m_pulse) m_cm += Circ;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rev_per_s", rev_per_s, m_rev);
      check("speed_cms", speed_cms, m_rev * Circ);
      check("distance_m", distance_m, (m_cm / 100 > 65535) ? 65535 : m_cm / 100);
      check("stopped", stopped, (m_zero >= Stop) ? 1 : 0);
      check("meas_valid", meas_valid, m_mv);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hi, input int lo);
    wheel_raw = 1'b1;
    cyc(hi);
    wheel_raw = 1'b0;
    cyc(lo);
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    cyc(1);
    tick_1s = 1'b0;
  endtask

  task automatic sat_pulses(input int n);
    repeat (n) begin
      raw_s = 1'b1;
      cyc(1);
      raw_s = 1'b0;
      cyc(1);
    end
    cyc(4);
  endtask

  // Saturation instance: 300 pulses in a window, then drive distance past 65535 m.
  initial begin
    cyc(3);
    rst_s = 1'b0;
    sat_pulses(300);
    tick_s = 1'b1;
    cyc(1);
    tick_s = 1'b0;
    check("sat_rev", rev_s, 255);
    check("sat_speed", speed_s, 65025);
    check("sat_valid", mv_s, 1);
    check("sat_stopped", stopped_s, 0);
    check("sat_dist_300", dist_s, 765);
    sat_pulses(25699 - 300);
    check("sat_dist_near", dist_s, 65532);
    sat_pulses(25);
    check("sat_dist_max", dist_s, 65535);
    sat_pulses(5);
    check("sat_dist_nowrap", dist_s, 65535);
    sat_done = 1'b1;
  end

  logic [11:0] bpat = 12'b1111_0101_0101;

  initial begin
    bit done;
    model_reset();
    cmp_en = 1'b1;
    cyc(3);
    check("rst_rev", rev_per_s, 0);
    check("rst_stopped", stopped, 1);
    check("rst_dist", distance_m, 0);
    reset = 1'b0;

    // Five clean pulses then a tick.
    repeat (5) press(5, 95);
    tick();
    check("t2_rev", rev_per_s, 5);
    check("t2_speed", speed_cms, 1050);
    check("t2_valid", meas_valid, 1);
    check("t2_stopped", stopped, 0);
    check("t2_dist", distance_m, 10);
    check("t2_model_rev", m_rev, 5);
    cyc(1);
    check("t2_valid_drop", meas_valid, 0);

    // Bouncy press counts once; a press 25 cycles after acceptance counts.
    for (int i = 0; i < 12; i++) begin
      wheel_raw = bpat[i];
      cyc(1);
    end
    wheel_raw = 1'b0;
    cyc(8);
    tick();
    check("t3_rev_bounce", rev_per_s, 1);
    check("t3_speed", speed_cms, 210);
    cyc(4);
    press(5, 40);
    tick();
    check("t3_rev_second", rev_per_s, 1);
    check("t3_dist", distance_m, 14);

    // Distance over ten pulses, then clear coinciding with an accepted pulse.
    tick();
    check("t4_rev_empty", rev_per_s, 0);
    clear_dist = 1'b1;
    cyc(1);
    clear_dist = 1'b0;
    check("t4_clear", distance_m, 0);
    repeat (10) press(5, 25);
    check("t4_dist21", distance_m, 21);
    check("t4_model_cm", m_cm, 2100);
    wheel_raw = 1'b1;
    cyc(2);
    clear_dist = 1'b1;
    cyc(1);
    clear_dist = 1'b0;
    check("t4_clear_pulse", distance_m, 0);
    cyc(2);
    wheel_raw = 1'b0;
    cyc(25);
    tick();
    check("t4_rev11", rev_per_s, 11);
    check("t4_speed", speed_cms, 2310);

    // Pulse on the tick edge goes to the next window; stop detection.
    repeat (2) press(5, 25);
    wheel_raw = 1'b1;
    cyc(2);
    tick_1s = 1'b1;
    cyc(1);
    tick_1s = 1'b0;
    check("t5_rev_excl", rev_per_s, 2);
    cyc(2);
    wheel_raw = 1'b0;
    cyc(20);
    tick();
    check("t5_rev_incl", rev_per_s, 1);
    cyc(10);
    tick();
    check("t5_stop1", stopped, 0);
    cyc(10);
    tick();
    check("t5_stop2", stopped, 0);
    cyc(10);
    tick();
    check("t5_stop3", stopped, 1);
    press(5, 20);
    tick();
    check("t5_restart", stopped, 0);
    check("t5_rev1", rev_per_s, 1);

    // Asynchronous reset mid-activity.
    press(5, 20);
    wheel_raw = 1'b1;
    cyc(1);
    #3 reset = 1'b1;
    #1;
    check("t1_rev", rev_per_s, 0);
    check("t1_speed", speed_cms, 0);
    check("t1_dist", distance_m, 0);
    check("t1_valid", meas_valid, 0);
    check("t1_stopped", stopped, 1);
    cyc(2);
    reset = 1'b0;
    cyc(3);
    wheel_raw = 1'b0;
    cyc(25);
    press(5, 20);
    check("t1_pre_tick_stopped", stopped, 1);
    check("t1_pre_tick_valid", meas_valid, 0);
    tick();
    check("t1_rev_after", rev_per_s, 2);
    check("t1_stopped_after", stopped, 0);
    cmp_en = 1'b0;

    done = 1'b0;
    for (int i = 0; i < 60000 && !done; i++) begin
      if (sat_done) done = 1'b1;
      else cyc(1);
    end
    check("sat_finished", done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
